// File: rtl/id_decode_stage.sv
// id_decode_stage: registered secondary-format decoder with 2-entry skid buffer and literal prefix
module id_decode_stage #(
  parameter int INSTR_W = 14,
  parameter int LIT_W   = 16,
  parameter int CTRL_W  = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [LIT_W-1:0]   out_lit,
  output logic               out_illegal
);
  typedef enum logic {IDLE, HELD} state_t;
  state_t state_q, state_d;
  logic [7:0] pfx_q, pfx_d;
  logic ov_q, ov_d, sv_q, sv_d, oi_q, oi_d, si_q, si_d;
  logic [CTRL_W-1:0] oc_q, oc_d, sc_q, sc_d, w_ctrl;
  logic [LIT_W-1:0] ol_q, ol_d, sl_q, sl_d, w_lit;
  logic [4:0] op;
  logic [3:0] cls;
  logic is_pfx, w_ill, acc, wv, free;
  // decode the incoming word; a held prefix widens the literal of classes 3..7
  always_comb begin
    op = in_instr[INSTR_W-1 -: 5];
    cls = op[4:2] == 3'b110 ? 4'd1 :
          op[4:2] == 3'b111 ? 4'd2 :
          op[4:2] == 3'b100 ? 4'd3 :
          op[4:2] == 3'b101 ? 4'd4 :
          op == 5'b01100    ? 4'd5 :
          op == 5'b01101    ? 4'd6 :
          op == 5'b00010    ? 4'd7 : 4'd0;
    is_pfx = op == 5'b00011;
    w_ill = cls == 4'd0 && !is_pfx;
    w_ctrl = cls == 4'd0 ? '0 : {cls, in_instr[10:8], {(CTRL_W-7){1'b0}}};
    w_lit = cls == 4'd0                       ? '0 :
            state_q == HELD && cls >= 4'd3    ? LIT_W'({pfx_q, in_instr[7:0]}) :
            cls <= 4'd2                       ? {{(LIT_W-8){in_instr[7]}}, in_instr[7:0]} :
            cls <= 4'd4                       ? LIT_W'(in_instr[7:0]) : LIT_W'(in_instr[8:0]);
  end
  // handshake, skid movement and prefix state; flush beats accept
  always_comb begin
    acc = in_valid && !sv_q && !flush;
    wv = acc && !is_pfx;
    free = !ov_q || out_ready;
    state_d = acc ? (is_pfx ? HELD : IDLE) : state_q;
    pfx_d = acc && is_pfx ? in_instr[7:0] : pfx_q;
    ov_d = ov_q;
    sv_d = sv_q;
    oc_d = oc_q;
    ol_d = ol_q;
    oi_d = oi_q;
    sc_d = sc_q;
    sl_d = sl_q;
    si_d = si_q;
    if (flush) begin
      ov_d = 1'b0;
      sv_d = 1'b0;
      state_d = IDLE;
    end else if (free && sv_q) begin
      sv_d = 1'b0;
      {oc_d, ol_d, oi_d} = {sc_q, sl_q, si_q};
    end else if (free) begin
      ov_d = wv;
      {oc_d, ol_d, oi_d} = wv ? {w_ctrl, w_lit, w_ill} : {oc_q, ol_q, oi_q};
    end else if (wv) begin
      sv_d = 1'b1;
      {sc_d, sl_d, si_d} = {w_ctrl, w_lit, w_ill};
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pfx_q <= '0;
      ov_q <= 1'b0;
      sv_q <= 1'b0;
      oc_q <= '0;
      ol_q <= '0;
      oi_q <= 1'b0;
      sc_q <= '0;
      sl_q <= '0;
      si_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pfx_q <= pfx_d;
      ov_q <= ov_d;
      sv_q <= sv_d;
      oc_q <= oc_d;
      ol_q <= ol_d;
      oi_q <= oi_d;
      sc_q <= sc_d;
      sl_q <= sl_d;
      si_q <= si_d;
    end
  end
  assign in_ready = !sv_q;
  assign out_valid = ov_q;
  assign out_ctrl = oc_q;
  assign out_lit = ol_q;
  assign out_illegal = oi_q;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed and randomized checks of id_decode_stage against a queue model
module tb_id_decode_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [13:0] in_instr = '0;
  logic in_ready, out_valid, out_illegal;
  logic [25:0] out_ctrl;
  logic [15:0] out_lit;
  int total = 0, bad = 0;
  typedef struct packed {logic [25:0] c; logic [15:0] l; logic i;} word_t;

  id_decode_stage dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_lit(out_lit), .out_illegal(out_illegal));

  always #5 clk = ~clk;

  function automatic void ref_dec(input logic [13:0] ins, input bit held, input logic [7:0] p,
                                  output word_t w, output bit pf);
    int cls;
    cls = 0;
    pf = 0;
    casez (ins[13:9])
      5'b110??: cls = 1;
      5'b111??: cls = 2;
      5'b100??: cls = 3;
      5'b101??: cls = 4;
      5'b01100: cls = 5;
      5'b01101: cls = 6;
      5'b00010: cls = 7;
      5'b00011: pf = 1;
      default:  cls = 0;
    endcase
    w.i = (cls == 0) && !pf;
    w.c = (cls == 0) ? 26'd0 : 26'(cls * (1 << 22) + ins[10:8] * (1 << 19));
    if (cls == 0) w.l = 16'd0;
    else if (held && cls >= 3) w.l = 16'(p * 256 + ins[7:0]);
    else if (cls <= 2) w.l = ins[7] ? 16'(ins[7:0]) + 16'hFF00 : 16'(ins[7:0]);
    else if (cls <= 4) w.l = 16'(ins[7:0]);
    else w.l = 16'(ins[8:0]);
  endfunction

  task automatic cyc(input bit v, input logic [13:0] ins, input bit r, input bit f);
    in_valid = v; in_instr = ins; out_ready = r; flush = f;
    @(posedge clk); @(negedge clk);
    in_valid = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (out_ctrl !== 26'd0) begin bad++; $display("FAIL rst_ctrl got=%h want=0", out_ctrl); end
    total++; if (out_lit !== 16'd0) begin bad++; $display("FAIL rst_lit got=%h want=0", out_lit); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL rst_ill got=%b want=0", out_illegal); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_brz();
    cyc(1, 14'h3380, 1, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL brz_valid got=%b want=1", out_valid); end
    total++; if (out_ctrl[25:22] !== 4'd1) begin bad++; $display("FAIL brz_class got=%0d want=1", out_ctrl[25:22]); end
    total++; if (out_ctrl[21:19] !== 3'b011) begin bad++; $display("FAIL brz_reg got=%b want=011", out_ctrl[21:19]); end
    total++; if (out_lit !== 16'hFF80) begin bad++; $display("FAIL brz_lit got=%h want=ff80", out_lit); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL brz_ill got=%b want=0", out_illegal); end
    cyc(0, 14'h0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL brz_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_prefix();
    cyc(1, 14'h0612, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pfx_nowword got=%b want=0", out_valid); end
    cyc(1, 14'h2034, 1, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pfx_valid got=%b want=1", out_valid); end
    total++; if (out_ctrl !== 26'h0C00000) begin bad++; $display("FAIL pfx_ctrl got=%h want=0c00000", out_ctrl); end
    total++; if (out_lit !== 16'h1234) begin bad++; $display("FAIL pfx_lit got=%h want=1234", out_lit); end
    cyc(1, 14'h2034, 1, 0);
    total++; if (out_lit !== 16'h0034) begin bad++; $display("FAIL pfx_once got=%h want=0034", out_lit); end
    cyc(0, 14'h0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pfx_single got=%b want=0", out_valid); end
  endtask

  task automatic test_skid();
    cyc(1, 14'h1905, 0, 0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL skid_rdy1 got=%b want=1", in_ready); end
    cyc(1, 14'h1A07, 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_rdy2 got=%b want=0", in_ready); end
    cyc(1, 14'h0409, 0, 0);
    total++; if (out_lit !== 16'h0105 || out_ctrl[25:22] !== 4'd5) begin bad++; $display("FAIL skid_first got=%h/%0d want=0105/5", out_lit, out_ctrl[25:22]); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_rdy3 got=%b want=0", in_ready); end
    cyc(0, 14'h0, 1, 0);
    total++; if (out_valid !== 1'b1 || out_lit !== 16'h0007 || out_ctrl[25:22] !== 4'd6) begin bad++; $display("FAIL skid_second got=%b/%h/%0d want=1/0007/6", out_valid, out_lit, out_ctrl[25:22]); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL skid_rdy4 got=%b want=1", in_ready); end
    cyc(0, 14'h0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_nothird got=%b want=0", out_valid); end
  endtask

  task automatic test_illegal();
    cyc(1, 14'h0000, 1, 0);
    total++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b/%b want=1/1", out_valid, out_illegal); end
    total++; if (out_ctrl !== 26'd0 || out_lit !== 16'd0) begin bad++; $display("FAIL ill_zero got=%h/%h want=0/0", out_ctrl, out_lit); end
    cyc(1, 14'h2034, 1, 0);
    total++; if (out_illegal !== 1'b0 || out_lit !== 16'h0034) begin bad++; $display("FAIL ill_after got=%b/%h want=0/0034", out_illegal, out_lit); end
    cyc(0, 14'h0, 1, 0);
  endtask

  task automatic test_flush();
    cyc(1, 14'h1905, 0, 0);
    cyc(1, 14'h1A07, 0, 0);
    cyc(1, 14'h2034, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", in_ready); end
    cyc(0, 14'h0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", out_valid); end
    cyc(1, 14'h0612, 1, 0);
    cyc(0, 14'h0, 1, 1);
    cyc(1, 14'h2034, 1, 0);
    total++; if (out_valid !== 1'b1 || out_lit !== 16'h0034) begin bad++; $display("FAIL flush_pfx got=%b/%h want=1/0034", out_valid, out_lit); end
    cyc(0, 14'h0, 1, 0);
  endtask

  task automatic test_branch_drops_prefix();
    cyc(1, 14'h0612, 1, 0);
    cyc(1, 14'h3E01, 1, 0);
    total++; if (out_ctrl[25:22] !== 4'd2 || out_lit !== 16'h0001) begin bad++; $display("FAIL brn_pfx got=%0d/%h want=2/0001", out_ctrl[25:22], out_lit); end
    cyc(1, 14'h2034, 1, 0);
    total++; if (out_lit !== 16'h0034) begin bad++; $display("FAIL brn_after got=%h want=0034", out_lit); end
    cyc(0, 14'h0, 1, 0);
  endtask

  task automatic test_reset_midstream();
    cyc(1, 14'h1905, 0, 0);
    cyc(1, 14'h0612, 0, 0);
    rst = 1; @(posedge clk); @(negedge clk); rst = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst got=%b/%b want=0/1", out_valid, in_ready); end
    cyc(1, 14'h2034, 1, 0);
    total++; if (out_lit !== 16'h0034) begin bad++; $display("FAIL mid_pfx got=%h want=0034", out_lit); end
    cyc(0, 14'h0, 1, 0);
  endtask

  task automatic test_random();
    word_t q[$];
    word_t w;
    bit held, pf, v, r, f, acc, xfer;
    logic [7:0] p;
    logic [31:0] rnd;
    logic [13:0] ins;
    held = 0; p = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, out_valid, q.size() > 0); end
      total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        total++;
        if (out_ctrl !== q[0].c || out_lit !== q[0].l || out_illegal !== q[0].i) begin
          bad++; $display("FAIL rnd_word n=%0d got=%h/%h/%b want=%h/%h/%b", n, out_ctrl, out_lit, out_illegal, q[0].c, q[0].l, q[0].i);
        end
      end
      rnd = $urandom;
      ins = rnd[13:0];
      if (rnd[31:30] == 2'b00) ins[13:9] = 5'b00011;
      v = $urandom_range(3) != 0;
      r = $urandom_range(2) != 0;
      f = $urandom_range(39) == 0;
      acc = v && (q.size() < 2) && !f;
      xfer = (q.size() > 0) && r;
      if (f) begin
        q.delete(); held = 0;
      end else begin
        if (xfer) void'(q.pop_front());
        if (acc) begin
          ref_dec(ins, held, p, w, pf);
          if (pf) begin held = 1; p = ins[7:0]; end
          else begin q.push_back(w); held = 0; end
        end
      end
      in_valid = v; in_instr = ins; out_ready = r; flush = f;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_brz();
    test_prefix();
    test_skid();
    test_illegal();
    test_flush();
    test_branch_drops_prefix();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
